// File: rtl/mult_pkg.sv
// ============================================================================
// Module  : mult_pkg
// Brief   : Shared widths, S1 payload type and word-select helper for the
//           multiplier tail stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int MULT_ROW_W = 64;
  localparam int MULT_RES_W = 32;
  localparam int MULT_TAG_W = 5;

  // Carry-save pair plus sideband, held between the 4:2 layer and the CPA.
  typedef struct packed {
    logic [MULT_ROW_W-1:0] s;
    logic [MULT_ROW_W-1:0] c;
    logic                  hi_sel;
    logic [MULT_TAG_W-1:0] tag;
  } s1_payload_t;

  function automatic logic [MULT_RES_W-1:0] mult_sel_word(
    input logic [MULT_ROW_W-1:0] prod,
    input logic                  hi_sel
  );
    return hi_sel ? prod[MULT_ROW_W-1 -: MULT_RES_W] : prod[MULT_RES_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/csa3_2_w64.sv
// ============================================================================
// Module  : csa3_2_w64
// Brief   : 3:2 carry-save adder; carry row is pre-shifted by one bit and the
//           carry out of the top bit is dropped (modulo 2^W arithmetic).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module csa3_2_w64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  logic [W-1:0] w_maj;

  assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = w_maj << 1;

endmodule

`default_nettype wire

// File: rtl/mult_tree_tail.sv
// ============================================================================
// Module  : mult_tree_tail
// Brief   : 4:2 carry-save layer + final CPA of the 32x32 multiplier, with
//           valid/ready flow control, flush and synchronous active-low reset.
//           Define MULT_TAIL_PIPE_EN for the two-stage (CSA | CPA) pipeline;
//           otherwise CSA and CPA share one cycle into the output register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_tree_tail
  import mult_pkg::*;
#(
  parameter int TAG_W = MULT_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [MULT_ROW_W-1:0] row0_i,
  input  logic [MULT_ROW_W-1:0] row1_i,
  input  logic [MULT_ROW_W-1:0] row2_i,
  input  logic [MULT_ROW_W-1:0] row3_i,
  input  logic                  hi_sel_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [MULT_RES_W-1:0] result_o,
  output logic [TAG_W-1:0]      tag_o
);

  logic [MULT_ROW_W-1:0] w_s1;
  logic [MULT_ROW_W-1:0] w_c1;
  logic [MULT_ROW_W-1:0] w_s2;
  logic [MULT_ROW_W-1:0] w_c2;

  logic [MULT_ROW_W-1:0] w_cpa_s;
  logic [MULT_ROW_W-1:0] w_cpa_c;
  logic                  w_cpa_hi;
  logic [TAG_W-1:0]      w_cpa_tag;
  logic                  w_cpa_valid;
  logic [MULT_ROW_W-1:0] w_prod;
  logic                  w_s2_adv;

  logic                  r_s2_valid;
  logic [MULT_RES_W-1:0] r_s2_result;
  logic [TAG_W-1:0]      r_s2_tag;

  csa3_2_w64 #(.W(MULT_ROW_W)) u_csa_a (
    .i_a     (row0_i),
    .i_b     (row1_i),
    .i_c     (row2_i),
    .o_sum   (w_s1),
    .o_carry (w_c1)
  );

  csa3_2_w64 #(.W(MULT_ROW_W)) u_csa_b (
    .i_a     (w_s1),
    .i_b     (w_c1),
    .i_c     (row3_i),
    .o_sum   (w_s2),
    .o_carry (w_c2)
  );

  assign w_s2_adv = !r_s2_valid || out_ready_i;

`ifdef MULT_TAIL_PIPE_EN
  s1_payload_t r_s1;
  logic        r_s1_valid;
  logic        w_s1_adv;

  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready_o = w_s1_adv;

  // Payload only loads on a real transfer so idle cycles do not toggle it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1.s      <= w_s2;
        r_s1.c      <= w_c2;
        r_s1.hi_sel <= hi_sel_i;
        r_s1.tag    <= MULT_TAG_W'(tag_i);
      end
    end
  end

  assign w_cpa_s     = r_s1.s;
  assign w_cpa_c     = r_s1.c;
  assign w_cpa_hi    = r_s1.hi_sel;
  assign w_cpa_tag   = TAG_W'(r_s1.tag);
  assign w_cpa_valid = r_s1_valid;
`else
  assign in_ready_o  = w_s2_adv;
  assign w_cpa_s     = w_s2;
  assign w_cpa_c     = w_c2;
  assign w_cpa_hi    = hi_sel_i;
  assign w_cpa_tag   = tag_i;
  assign w_cpa_valid = in_valid_i;
`endif

  assign w_prod = w_cpa_s + w_cpa_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
    end else if (flush_i) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= w_cpa_valid;
      if (w_cpa_valid) begin
        r_s2_result <= mult_sel_word(w_prod, w_cpa_hi);
        r_s2_tag    <= w_cpa_tag;
      end
    end
  end

  assign out_valid_o = r_s2_valid;
  assign result_o    = r_s2_result;
  assign tag_o       = r_s2_tag;

endmodule

`default_nettype wire

// File: tb/tb_mult_tree_tail.sv
// ============================================================================
// Module  : tb_mult_tree_tail
// Brief   : Self-checking bench for mult_tree_tail (queue-based reference
//           model, directed cases and randomized traffic).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_tree_tail;
  import mult_pkg::*;

`ifdef MULT_TAIL_PIPE_EN
  localparam int LAT = 2;
  localparam int CAP = 2;
`else
  localparam int LAT = 1;
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, hi_sel, flush, out_valid, out_ready;
  logic [63:0] row0, row1, row2, row3;
  logic [4:0]  tag, tag_out;
  logic [31:0] result;

  always #5 clk = ~clk;

  mult_tree_tail #(.TAG_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .row0_i      (row0),
    .row1_i      (row1),
    .row2_i      (row2),
    .row3_i      (row3),
    .hi_sel_i    (hi_sel),
    .tag_i       (tag),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .tag_o       (tag_out)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cy;
  } op_t;

  op_t         exp_q[$];   // model: ops in flight, oldest first, cy = offer cycle
  op_t         act_log[$]; // observed output transfers, cy = transfer cycle
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          was_reset;
  logic        seen_valid = 1'b0;
  logic [31:0] seen_res;
  logic [4:0]  seen_tag;

  function automatic logic [31:0] ref_word(input logic [63:0] a, b, c, d, input logic hi);
    logic [63:0] p;
    p = a + b + c + d;
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_out_valid();
    return exp_q.size() > 0 && cyc >= exp_q[0].cy + LAT;
  endfunction

  task automatic compare();
    bit ov;
    ov = model_out_valid();
    check("out_valid", out_valid, ov);
    check("in_ready", in_ready, (exp_q.size() < CAP) || out_ready);
    if (ov) begin
      check("result", result, exp_q[0].res);
      check("tag", tag_out, exp_q[0].tag);
    end
    if (was_reset) begin
      check("reset_result", result, 0);
      check("reset_tag", tag_out, 0);
    end
    seen_valid = out_valid;
    seen_res   = result;
    seen_tag   = tag_out;
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic step();
    bit  ov, ir;
    op_t e, a;
    @(posedge clk);
    if (rst_n && !flush && seen_valid && out_ready) begin
      a.res = seen_res; a.tag = seen_tag; a.cy = cyc;
      act_log.push_back(a);
    end
    ov = model_out_valid();
    ir = (exp_q.size() < CAP) || out_ready;
    was_reset = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      was_reset = 1'b1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (ov && out_ready) void'(exp_q.pop_front());
      if (in_valid && ir) begin
        e.res = ref_word(row0, row1, row2, row3, hi_sel);
        e.tag = tag;
        e.cy  = cyc;
        exp_q.push_back(e);
      end
    end
    cyc++;
    #1;
    compare();
  endtask

  task automatic set_op(input logic [63:0] a, b, c, d, input logic hi, input logic [4:0] t);
    in_valid = 1'b1; row0 = a; row1 = b; row2 = c; row3 = d; hi_sel = hi; tag = t;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, k, guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    row0 = '0; row1 = '0; row2 = '0; row3 = '0; hi_sel = 1'b0; tag = '0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_tag", tag_out, 0);
    rst_n = 1'b1;
    step();

    // Basic add, latency and tag echo.
    act_log.delete();
    c0 = cyc;
    set_op(64'd5, 64'd7, 64'd0, 64'd0, 1'b0, 5'd3);
    step(); idle();
    repeat (LAT + 1) step();
    check("t1_count", act_log.size(), 1);
    if (act_log.size() >= 1) begin
      check("t1_result", act_log[0].res, 32'd12);
      check("t1_tag", act_log[0].tag, 5'd3);
      check("t1_latency", act_log[0].cy - c0, LAT);
    end

    // High then low word back-to-back.
    act_log.delete();
    set_op(64'hFFFF_FFFE_0000_0001, 0, 0, 0, 1'b1, 5'd4); step();
    set_op(64'hFFFF_FFFE_0000_0001, 0, 0, 0, 1'b0, 5'd5); step();
    idle();
    repeat (LAT + 2) step();
    check("t2_count", act_log.size(), 2);
    if (act_log.size() >= 2) begin
      check("t2_hi", act_log[0].res, 32'hFFFF_FFFE);
      check("t2_lo", act_log[1].res, 32'h0000_0001);
      check("t2_spacing", act_log[1].cy - act_log[0].cy, 1);
    end

    // Modulo-2^64 wrap cases.
    act_log.delete();
    set_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 1'b1, 5'd6); step();
    set_op({64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, 1'b0, 5'd7); step();
    idle();
    repeat (LAT + 2) step();
    check("t3_count", act_log.size(), 2);
    if (act_log.size() >= 2) begin
      check("t3_wrap_hi", act_log[0].res, 32'h0);
      check("t3_allones", act_log[1].res, 32'hFFFF_FFFC);
    end

    // Back-pressure: offer 4 ops while the consumer stalls for 5 cycles.
    act_log.delete();
    out_ready = 1'b0;
    k = 0;
    repeat (5) begin
      set_op(64'd1000 + 64'(k), 0, 0, 0, 1'b0, 5'(10 + k));
      #1;
      if (in_ready) begin step(); k++; end
      else step();
    end
    check("t4_accepted", k, CAP);
    check("t4_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    guard = 0;
    while (k < 4 && guard < 20) begin
      set_op(64'd1000 + 64'(k), 0, 0, 0, 1'b0, 5'(10 + k));
      #1;
      if (in_ready) begin step(); k++; end
      else step();
      guard++;
    end
    check("t4_all_accepted", k, 4);
    idle();
    repeat (LAT + 2) step();
    check("t4_count", act_log.size(), 4);
    for (int i = 0; i < 4 && i < act_log.size(); i++) begin
      check("t4_order", act_log[i].res, 32'd1000 + 32'(i));
    end
    if (act_log.size() >= 2) check("t4_spacing", act_log[1].cy - act_log[0].cy, 1);

    // Flush with ops in flight and a new op offered in the flush cycle.
    act_log.delete();
    out_ready = 1'b0;
    set_op(64'd21, 0, 0, 0, 1'b0, 5'd20); step();
    set_op(64'd22, 0, 0, 0, 1'b0, 5'd21); step();
    set_op(64'd23, 0, 0, 0, 1'b0, 5'd22); flush = 1'b1; step();
    flush = 1'b0; idle();
    check("t5_flush_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (4) step();
    check("t5_none_out", act_log.size(), 0);
    c0 = cyc;
    set_op(64'd40, 64'd2, 0, 0, 1'b0, 5'd23); step(); idle();
    repeat (LAT + 1) step();
    check("t5_post_count", act_log.size(), 1);
    if (act_log.size() >= 1) begin
      check("t5_post_result", act_log[0].res, 32'd42);
      check("t5_post_latency", act_log[0].cy - c0, LAT);
    end

    // Reset with the output stage full and stalled.
    act_log.delete();
    out_ready = 1'b0;
    set_op(64'd9, 64'd9, 0, 0, 1'b0, 5'd25); step(); idle();
    repeat (LAT) step();
    check("t6_full", out_valid, 1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("t6_valid", out_valid, 0);
    check("t6_result", result, 0);
    check("t6_tag", tag_out, 0);
    out_ready = 1'b1;
    set_op(64'd100, 64'd1, 64'd2, 64'd3, 1'b0, 5'd26); step(); idle();
    repeat (LAT + 1) step();
    check("t6_count", act_log.size(), 1);
    if (act_log.size() >= 1) check("t6_post_result", act_log[0].res, 32'd106);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int mode;
      mode = $urandom_range(0, 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      hi_sel    = $urandom_range(0, 1);
      tag       = 5'($urandom);
      if (mode == 0) begin
        row0 = {64{1'b1}}; row1 = {64{1'b1}}; row2 = {64{1'b1}}; row3 = {64{1'b1}};
      end else if (mode == 1) begin
        row0 = {$urandom, $urandom}; row1 = '0; row2 = '0; row3 = '0;
      end else begin
        row0 = {$urandom, $urandom}; row1 = {$urandom, $urandom};
        row2 = {$urandom, $urandom}; row3 = {$urandom, $urandom};
      end
      step();
    end

    rst_n = 1'b1; flush = 1'b0; idle(); out_ready = 1'b1;
    repeat (LAT + 3) step();
    check("final_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
